// File: rtl/interp_tap_accumulator.sv
// Transposed-form 3-tap accumulator (coefficients 2,3,2) fed by MCM products,
// with round-half-up normalisation, saturation and a single ready/valid output register.
module interp_tap_accumulator #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 32,
  parameter int SHIFT  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] p1,
  input  logic signed [DATA_W-1:0] p2,
  input  logic signed [DATA_W-1:0] p3,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     sat
);

  localparam int ACC_W = DATA_W + 3;
  localparam int unsigned RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  // SHIFT == 0 collapses to a zero rounding constant and a zero shift
  localparam logic signed [ACC_W-1:0] RND  = (SHIFT > 0) ? ACC_W'(1) << RND_POS : ACC_W'(0);
  localparam logic signed [ACC_W-1:0] OMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OMIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {FILL_0, FILL_1, FILL_FULL} fill_e;

  fill_e                    fill_q, fill_d;
  logic signed [ACC_W-1:0]  r0_q, r0_d, r1_q, r1_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     sat_q, sat_d;
  logic                     out_valid_q, out_valid_d;

  logic signed [ACC_W-1:0]  p1_x, p2_x, p3_x, sum, res;
  logic signed [OUT_W-1:0]  clip_data;
  logic                     clip_sat;
  logic                     accept;

  assign in_ready  = !flush && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat       = sat_q;

  always_comb begin
    p1_x = {{(ACC_W-DATA_W){p1[DATA_W-1]}}, p1};
    p2_x = {{(ACC_W-DATA_W){p2[DATA_W-1]}}, p2};
    p3_x = {{(ACC_W-DATA_W){p3[DATA_W-1]}}, p3};
    sum  = p1_x + r0_q;
    res  = (sum + RND) >>> SHIFT;
    if (res > OMAX) begin
      clip_data = OMAX[OUT_W-1:0];
      clip_sat  = 1'b1;
    end else if (res < OMIN) begin
      clip_data = OMIN[OUT_W-1:0];
      clip_sat  = 1'b1;
    end else begin
      clip_data = res[OUT_W-1:0];
      clip_sat  = 1'b0;
    end
  end

  always_comb begin
    r0_d        = r0_q;
    r1_d        = r1_q;
    fill_d      = fill_q;
    out_data_d  = out_data_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      r0_d        = '0;
      r1_d        = '0;
      fill_d      = FILL_0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      r0_d = p2_x + r1_q;
      r1_d = p3_x;
      case (fill_q)
        FILL_0:  fill_d = FILL_1;
        FILL_1:  fill_d = FILL_FULL;
        default: fill_d = FILL_FULL;
      endcase
      if (fill_q == FILL_FULL) begin
        out_data_d  = clip_data;
        sat_d       = clip_sat;
        out_valid_d = 1'b1;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_q        <= '0;
      r1_q        <= '0;
      fill_q      <= FILL_0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      r0_q        <= r0_d;
      r1_q        <= r1_d;
      fill_q      <= fill_d;
      out_data_q  <= out_data_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
